ooo_decode_execute_buffer: RTL and testbench
============================================

Name: ooo_decode_execute_buffer

Overview:
- Parametrised decoupling buffer between the decode and execute stages of the OoO core.
- Replaces the bare decode-to-execute wire bundle with a DEPTH-entry circular FIFO of decoded packets, using a valid/ready handshake on both sides.
- Adds pipeline flush (mispredict/exception), halt-instruction fencing and an occupancy count.
- Decode pushes flattened packets; execute pops them in program order.

Parameters:
- DATA_W, 512, width of one flattened decoded packet (opcode, operands, control-signal structs, tracker sigs).
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- CLK  input  1  core clock
- nRST  input  1  reset; synchronous, active-low
- flush  input  1  discard all buffered and in-flight packets
- din_valid  input  1  decode presents a packet
- din_ready  output  1  buffer can accept a packet this cycle
- din_data  input  DATA_W  decoded packet
- din_halt  input  1  packet carries halt_instr
- dout_valid  output  1  head packet available to execute
- dout_ready  input  1  execute accepts the head (low while any FU stalls)
- dout_data  output  DATA_W  head packet
- dout_halt  output  1  head packet carries halt_instr
- count  output  CNT_W  current occupancy
- halt_pending  output  1  a halt packet has been accepted and not yet flushed

Behaviour:
- Clock and reset: single clock CLK. Reset nRST is synchronous and active-low, sampled on the rising edge of CLK.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, halt_pending=0, dout_valid=0, din_ready=1. dout_data is don't-care.
- Pointers: log2(DEPTH)+1 bits each; the MSB is the wrap bit.
  - empty = (rd_ptr==wr_ptr).
  - full = index bits equal and wrap bits differ.
  - Wrap-around is natural modulo 2*DEPTH.
- Handshakes:
  - push = din_valid & din_ready & ~flush.
  - pop = dout_valid & dout_ready & ~flush.
  - din_ready = ~full & ~halt_pending. It does not depend combinationally on dout_ready, so a full buffer cannot push on the same cycle it pops.
  - dout_valid = ~empty.
  - dout_data and dout_halt are read from the head entry, combinationally from the storage array.
- Latency: a pushed packet is visible on dout on the next cycle; minimum latency is 1.
- Simultaneous push and pop when not full and not empty: both happen and count is unchanged.
- count is incremented on push only, decremented on pop only, and never exceeds DEPTH.
- Halt fencing:
  - Accepting a packet with din_halt=1 sets halt_pending on the next edge.
  - din_ready then stays 0 until flush or reset.
  - Packets already buffered continue to drain normally.
- Flush has priority over everything:
  - On the next edge rd_ptr=wr_ptr=0, count=0, halt_pending=0.
  - Any push or pop asserted in the flush cycle is ignored. dout_valid in the flush cycle still reflects the pre-flush state, but execute must not commit.
- Reset mid-operation: identical effect to flush, plus the reset values above.
- Storage array is not cleared on flush or reset; only the pointers matter.

Optional Feature:
- Macro OOO_DE_BUFFER_BYPASS_EN.
- When defined, a fall-through path applies when the buffer is empty, din_valid=1, dout_ready=1 and flush=0:
  - dout_valid=1 and dout_data/dout_halt = din_data/din_halt combinationally.
  - The packet is consumed with 0-cycle latency; nothing is written and count stays 0.
  - halt_pending is still set if din_halt=1.
- When undefined: no combinational din-to-dout path; latency is always at least 1 cycle.

Decomposition:
- Package ooo_de_buffer_pkg holds:
  - de_packet_t, the packed struct of the decoded fields (pc, pc4, instr, immediate, port_a, port_b, store_data, reg_file_wdata, opcode, sfu_type, the FU control structs, exception/csr/tracker structs), from which DATA_W is sized;
  - the DE_DEPTH_DEFAULT constant.
- One sub-module: ooo_de_buffer_mem, a DEPTH x DATA_W register array with one write port and one asynchronous read port and no reset.

Test Plan (DEPTH=4, DATA_W=32 unless noted):
- Fill/drain: push 0xA0..0xA3 with dout_ready=0 → count=4, din_ready=0. Then set dout_ready=1 → pops 0xA0,0xA1,0xA2,0xA3 in order, count reaches 0 and dout_valid=0.
- Wrap-around: 10 cycles of continuous push and pop with dout_ready=1, data 0x00..0x09 → every value appears exactly once in order, one cycle late, with count steady at 1.
- Full + pop: hold 4 entries, assert din_valid and dout_ready together → pop occurs, push is blocked that cycle (din_ready=0); next cycle the push is accepted and count=4.
- Halt fence: push 0x11, then 0x22 with din_halt=1, then attempt 0x33 → halt_pending=1, din_ready=0, 0x33 is never accepted, and 0x11, 0x22 drain with dout_halt=1 on 0x22.
- Flush: with 3 entries, assert flush together with din_valid (0x55) and dout_ready → next cycle count=0, dout_valid=0, halt_pending=0, and 0x55 is never seen.
- Reset and bypass: drive nRST=0 for one edge mid-fill → all reset values hold. With OOO_DE_BUFFER_BYPASS_EN, empty buffer, push 0x77 with dout_ready=1 → dout_data=0x77 in the same cycle and count stays 0.

Source files
------------

// File: rtl/ooo_de_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ooo_de_buffer_pkg
// Purpose  : Shared types and constants for the decode-to-execute buffer.
//            de_packet_t is the flattened decoded packet that decode pushes
//            and execute pops; DE_PACKET_W sizes the buffer data path.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ooo_de_buffer_pkg;

   localparam int DE_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [1:0] src_a_sel;
      logic [1:0] src_b_sel;
      logic       reg_write;
      logic [6:0] rsvd;
   } alu_ctrl_t;                        // 16 bits

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] width;
      logic       sign_ext;
      logic [9:0] rsvd;
   } mem_ctrl_t;                        // 16 bits

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [2:0] cond;
      logic [9:0] rsvd;
   } branch_ctrl_t;                     // 16 bits

   typedef struct packed {
      logic        valid;
      logic [4:0]  cause;
      logic [25:0] tval;
   } exception_t;                       // 32 bits

   typedef struct packed {
      logic        en;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [16:0] rsvd;
   } csr_t;                             // 32 bits

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [5:0]  rob_tag;
      logic [6:0]  phys_rd;
      logic [6:0]  phys_rs1;
      logic [6:0]  phys_rs2;
      logic [31:0] seq_num;
      logic [31:0] hazard_sig;
      logic [15:0] branch_mask;
      logic [11:0] rsvd;
   } tracker_t;                         // 134 bits

   typedef struct packed {
      logic [31:0]  pc;
      logic [31:0]  pc4;
      logic [31:0]  instr;
      logic [31:0]  immediate;
      logic [31:0]  port_a;
      logic [31:0]  port_b;
      logic [31:0]  store_data;
      logic [31:0]  reg_file_wdata;
      logic [6:0]   opcode;
      logic [2:0]   sfu_type;
      alu_ctrl_t    alu_ctrl;
      mem_ctrl_t    mem_ctrl;
      branch_ctrl_t branch_ctrl;
      exception_t   exception;
      csr_t         csr;
      tracker_t     tracker;
   } de_packet_t;                       // 512 bits

   localparam int DE_PACKET_W = $bits(de_packet_t);

endpackage
`default_nettype wire

// File: rtl/ooo_de_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : ooo_de_buffer_mem
// Purpose  : DEPTH x WIDTH register array, one synchronous write port and one
//            asynchronous read port. Contents are never reset.
// Ports    : i_clk   clock
//            i_we    write enable
//            i_waddr write index
//            i_wdata write data
//            i_raddr read index
//            o_rdata read data (combinational)
// Revision : 1.0  initial release
// ============================================================================
module ooo_de_buffer_mem
   import ooo_de_buffer_pkg::*;
#(
   parameter int WIDTH = DE_PACKET_W,
   parameter int DEPTH = DE_DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ooo_decode_execute_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ooo_decode_execute_buffer
// Purpose  : DEPTH-entry circular FIFO between decode and execute with
//            valid/ready on both sides, flush, halt fencing and occupancy.
//            Optional macro OOO_DE_BUFFER_BYPASS_EN adds an empty-buffer
//            fall-through path from din to dout.
// Ports    : CLK          core clock
//            nRST         synchronous active-low reset
//            flush        discard all buffered / in-flight packets
//            din_valid    decode presents a packet
//            din_ready    buffer accepts a packet this cycle
//            din_data     decoded packet
//            din_halt     packet carries halt_instr
//            dout_valid   head packet available
//            dout_ready   execute accepts the head
//            dout_data    head packet
//            dout_halt    head packet carries halt_instr
//            count        current occupancy
//            halt_pending halt packet accepted and not yet flushed
// Revision : 1.0  initial release
// ============================================================================
module ooo_decode_execute_buffer
   import ooo_de_buffer_pkg::*;
#(
   parameter int DATA_W = DE_PACKET_W,
   parameter int DEPTH  = DE_DEPTH_DEFAULT,
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din_data,
   input  logic              din_halt,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_halt,
   output logic [CNT_W-1:0]  count,
   output logic              halt_pending
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_PTR_W = c_IDX_W + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_halt_pending;

   logic               w_empty;
   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic               w_bypass;
   logic               w_halt_accept;
   logic [DATA_W:0]    w_mem_rdata;

   assign w_empty = (r_rd_ptr == r_wr_ptr);
   // Full: same slot index but one pointer has lapped the other.
   assign w_full  = (r_rd_ptr[c_IDX_W-1:0] == r_wr_ptr[c_IDX_W-1:0]) &&
                    (r_rd_ptr[c_IDX_W] != r_wr_ptr[c_IDX_W]);

   // Ready ignores dout_ready on purpose: a full buffer never pushes and
   // pops in the same cycle, keeping din_ready off the execute stall path.
   assign din_ready = ~w_full & ~r_halt_pending;

`ifdef OOO_DE_BUFFER_BYPASS_EN
   // Fall-through only when nothing is queued ahead and the fence is open.
   assign w_bypass   = w_empty & din_valid & ~r_halt_pending & dout_ready & ~flush;
   assign dout_valid = ~w_empty | w_bypass;
   assign dout_data  = w_bypass ? din_data : w_mem_rdata[DATA_W-1:0];
   assign dout_halt  = w_bypass ? din_halt : w_mem_rdata[DATA_W];
`else
   assign w_bypass   = 1'b0;
   assign dout_valid = ~w_empty;
   assign dout_data  = w_mem_rdata[DATA_W-1:0];
   assign dout_halt  = w_mem_rdata[DATA_W];
`endif

   // A bypassed packet is consumed directly, so it neither writes nor pops.
   assign w_push        = din_valid & din_ready & ~flush & ~w_bypass;
   assign w_pop         = dout_valid & dout_ready & ~flush & ~w_bypass;
   assign w_halt_accept = din_halt & (w_push | w_bypass);

   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= '0;
         r_halt_pending <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_halt_accept) begin
            r_halt_pending <= 1'b1;
         end
      end
   end

   assign count        = r_count;
   assign halt_pending = r_halt_pending;

   // Halt flag is stored alongside the packet as the top bit of each entry.
   ooo_de_buffer_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk   (CLK),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[c_IDX_W-1:0]),
      .i_wdata ({din_halt, din_data}),
      .i_raddr (r_rd_ptr[c_IDX_W-1:0]),
      .o_rdata (w_mem_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_ooo_decode_execute_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooo_decode_execute_buffer
// Purpose  : Self-checking bench for ooo_decode_execute_buffer with
//            DEPTH=4, DATA_W=32. Table of per-cycle vectors plus short
//            hand-written sequences (drain ordering, optional bypass).
// Revision : 1.0  initial release
// ============================================================================
module tb_ooo_decode_execute_buffer;

   localparam int DW = 32;
   localparam int DP = 4;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          flush;
   logic          din_valid;
   logic          din_ready;
   logic [DW-1:0] din_data;
   logic          din_halt;
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic          dout_halt;
   logic [2:0]    count;
   logic          halt_pending;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   ooo_decode_execute_buffer #(
      .DATA_W (DW),
      .DEPTH  (DP)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .flush        (flush),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .din_data     (din_data),
      .din_halt     (din_halt),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout_data    (dout_data),
      .dout_halt    (dout_halt),
      .count        (count),
      .halt_pending (halt_pending)
   );

   // One cycle: inputs driven, and outputs expected just before the edge.
   typedef struct {
      logic        rn;
      logic        fl;
      logic        dv;
      logic [31:0] dd;
      logic        dh;
      logic        dr;
      logic        e_dv;
      logic [31:0] e_dd;
      logic        e_dh;
      logic        e_rdy;
      logic [2:0]  e_cnt;
      logic        e_hp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t V(int rn, int fl, int dv, int dd, int dh, int dr,
                              int e_dv, int e_dd, int e_dh, int e_rdy,
                              int e_cnt, int e_hp);
      vec_t v;
      v.rn = rn[0]; v.fl = fl[0]; v.dv = dv[0]; v.dd = 32'(dd);
      v.dh = dh[0]; v.dr = dr[0]; v.e_dv = e_dv[0]; v.e_dd = 32'(e_dd);
      v.e_dh = e_dh[0]; v.e_rdy = e_rdy[0]; v.e_cnt = 3'(e_cnt);
      v.e_hp = e_hp[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] got[$];
      int n;

      // ---------------- vector table ----------------
      vecs.push_back(V(1,0,0,0,0,0,       0,0,0,1,0,0));      // reset state
      // fill A0..A3 with execute stalled
      vecs.push_back(V(1,0,1,'hA0,0,0,    0,0,0,1,0,0));
      vecs.push_back(V(1,0,1,'hA1,0,0,    1,'hA0,0,1,1,0));
      vecs.push_back(V(1,0,1,'hA2,0,0,    1,'hA0,0,1,2,0));
      vecs.push_back(V(1,0,1,'hA3,0,0,    1,'hA0,0,1,3,0));
      vecs.push_back(V(1,0,0,0,0,0,       1,'hA0,0,0,4,0));
      // drain in order
      vecs.push_back(V(1,0,0,0,0,1,       1,'hA0,0,0,4,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hA1,0,1,3,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hA2,0,1,2,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hA3,0,1,1,0));
      vecs.push_back(V(1,0,0,0,0,1,       0,0,0,1,0,0));
      // wrap-around streaming, count steady at 1
      vecs.push_back(V(1,0,1,0,0,0,       0,0,0,1,0,0));
      for (int i = 1; i < 10; i++)
         vecs.push_back(V(1,0,1,i,0,1,    1,i-1,0,1,1,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,9,0,1,1,0));
      vecs.push_back(V(1,0,0,0,0,1,       0,0,0,1,0,0));
      // full + pop: push blocked on the popping cycle
      for (int i = 0; i < 4; i++)
         vecs.push_back(V(1,0,1,'hB0+i,0,0, (i > 0) ? 1 : 0,(i > 0) ? 'hB0 : 0,0,1,i,0));
      vecs.push_back(V(1,0,1,'hB4,0,1,    1,'hB0,0,0,4,0));
      vecs.push_back(V(1,0,1,'hB4,0,0,    1,'hB1,0,1,3,0));
      vecs.push_back(V(1,0,0,0,0,0,       1,'hB1,0,0,4,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hB1,0,0,4,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hB2,0,1,3,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hB3,0,1,2,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'hB4,0,1,1,0));
      vecs.push_back(V(1,0,0,0,0,1,       0,0,0,1,0,0));
      // halt fence
      vecs.push_back(V(1,0,1,'h11,0,0,    0,0,0,1,0,0));
      vecs.push_back(V(1,0,1,'h22,1,0,    1,'h11,0,1,1,0));
      vecs.push_back(V(1,0,1,'h33,0,0,    1,'h11,0,0,2,1));
      vecs.push_back(V(1,0,1,'h33,0,1,    1,'h11,0,0,2,1));
      vecs.push_back(V(1,0,1,'h33,0,1,    1,'h22,1,0,1,1));
      vecs.push_back(V(1,0,1,'h33,0,1,    0,0,0,0,0,1));
      vecs.push_back(V(1,1,0,0,0,0,       0,0,0,0,0,1));
      vecs.push_back(V(1,0,0,0,0,0,       0,0,0,1,0,0));
      // flush with concurrent push and pop
      vecs.push_back(V(1,0,1,'hC0,0,0,    0,0,0,1,0,0));
      vecs.push_back(V(1,0,1,'hC1,0,0,    1,'hC0,0,1,1,0));
      vecs.push_back(V(1,0,1,'hC2,0,0,    1,'hC0,0,1,2,0));
      vecs.push_back(V(1,1,1,'h55,0,1,    1,'hC0,0,1,3,0));
      vecs.push_back(V(1,0,0,0,0,1,       0,0,0,1,0,0));
      vecs.push_back(V(1,0,1,'h66,0,0,    0,0,0,1,0,0));
      vecs.push_back(V(1,0,0,0,0,1,       1,'h66,0,1,1,0));
      vecs.push_back(V(1,0,0,0,0,0,       0,0,0,1,0,0));
      // reset mid-fill, with a halt packet offered during reset
      vecs.push_back(V(1,0,1,'hD0,0,0,    0,0,0,1,0,0));
      vecs.push_back(V(1,0,1,'hD1,0,0,    1,'hD0,0,1,1,0));
      vecs.push_back(V(0,0,1,'hD2,1,0,    1,'hD0,0,1,2,0));
      vecs.push_back(V(1,0,0,0,0,0,       0,0,0,1,0,0));

      // ---------------- reset ----------------
      nRST = 1'b0; flush = 1'b0; din_valid = 1'b0; din_data = '0;
      din_halt = 1'b0; dout_ready = 1'b0;
      repeat (2) @(posedge CLK);

      // ---------------- apply table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         nRST       = vecs[i].rn;
         flush      = vecs[i].fl;
         din_valid  = vecs[i].dv;
         din_data   = vecs[i].dd;
         din_halt   = vecs[i].dh;
         dout_ready = vecs[i].dr;
         #1;
         chk($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].e_dv));
         chk($sformatf("v%0d din_ready", i), 32'(din_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d halt_pending", i), 32'(halt_pending), 32'(vecs[i].e_hp));
         if (vecs[i].e_dv) begin
            chk($sformatf("v%0d dout_data", i), dout_data, vecs[i].e_dd);
            chk($sformatf("v%0d dout_halt", i), 32'(dout_halt), 32'(vecs[i].e_dh));
         end
      end

      // ---------------- drain ordering with bounded wait ----------------
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         nRST = 1'b1; flush = 1'b0; dout_ready = 1'b0;
         din_valid = 1'b1; din_data = 32'hE0 + 32'(i); din_halt = 1'b0;
      end
      @(negedge CLK);
      din_valid = 1'b0;
      #1;
      chk("fill_din_ready", 32'(din_ready), 32'd0);
      chk("fill_count", 32'(count), 32'd4);
      dout_ready = 1'b1;
      #1;
      n = 0;
      while (dout_valid && n < 20) begin
         got.push_back(dout_data);
         @(negedge CLK);
         #1;
         n++;
      end
      chk("drain_in_bound", 32'(n < 20), 32'd1);
      chk("drain_len", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < got.size())
            chk($sformatf("drain_%0d", k), got[k], 32'hE0 + 32'(k));
      chk("drain_count", 32'(count), 32'd0);

`ifdef OOO_DE_BUFFER_BYPASS_EN
      // ---------------- zero-latency fall-through ----------------
      @(negedge CLK);
      dout_ready = 1'b1; din_valid = 1'b1; din_data = 32'h77; din_halt = 1'b0;
      #1;
      chk("byp_dout_valid", 32'(dout_valid), 32'd1);
      chk("byp_dout_data", dout_data, 32'h77);
      chk("byp_count", 32'(count), 32'd0);
      @(negedge CLK);
      din_valid = 1'b0;
      #1;
      chk("byp_after_valid", 32'(dout_valid), 32'd0);
      chk("byp_after_count", 32'(count), 32'd0);
      @(negedge CLK);
      din_valid = 1'b1; din_data = 32'h88; din_halt = 1'b1;
      #1;
      chk("byp_halt_data", dout_data, 32'h88);
      chk("byp_halt_flag", 32'(dout_halt), 32'd1);
      @(negedge CLK);
      din_valid = 1'b0; din_halt = 1'b0;
      #1;
      chk("byp_halt_pending", 32'(halt_pending), 32'd1);
      chk("byp_halt_ready", 32'(din_ready), 32'd0);
      chk("byp_halt_count", 32'(count), 32'd0);
      @(negedge CLK);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      #1;
      chk("byp_flush_hp", 32'(halt_pending), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
